uart_tx: RTL

- UART transmitter; serialises one byte per frame: start bit, data bits LSB first, optional parity bit, stop bit(s).
- Paced by the external 16x-oversampling sample-tick enable (`s_tick`), the same one that drives the receiver. Not a clock.
- Sits between the AES result path and the serial pin.
- 8N1 at 16 ticks per bit by default; idle line is high.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and default
// frame geometry. Used by both the transmitter and the receiver.
package uart_pkg;

    // Frame-sequencer states, 3-bit encoding shared with the receiver.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // s_ticks per bit period.
    localparam int unsigned OVERSAMPLE      = 16;

    // Default frame: 8 data bits, one stop bit.
    localparam int unsigned DBIT_DEFAULT    = 8;
    localparam int unsigned SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity
// bit, stop bit(s). Paced by the external 16x oversampling enable s_tick.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit after
// the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = DBIT_DEFAULT,
    parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam logic [4:0] BitLast  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
    localparam logic [2:0] DataLast = 3'(DBIT - 1);

    uart_state_e state_q, state_d;
    logic [4:0]  s_cnt_q, s_cnt_d;
    logic [2:0]  n_cnt_q, n_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

`ifdef UART_TX_PARITY_EN
    localparam logic [7:0] DataMask = 8'((1 << DBIT) - 1);
    logic        parity_q, parity_d;
`endif

    // Strobes for the last s_tick of a bit period and of the stop period.
    logic bit_end;
    logic stop_end;
    logic last_bit;

    assign bit_end  = s_tick && (s_cnt_q == BitLast);
    assign stop_end = s_tick && (s_cnt_q == StopLast);
    assign last_bit = (n_cnt_q == DataLast);

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: advance on the last s_tick of each phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tx_start) state_d = StStart;
            StStart: if (bit_end) state_d = StData;
            StData: begin
                if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: if (bit_end) state_d = StStop;
`endif
            StStop:  if (stop_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered outputs: counters, shifter, serial level, done pulse.
    always_comb begin
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                // A coincident s_tick is not counted: the start bit begins here.
                if (tx_start) begin
                    shift_d = din;
                    s_cnt_d = '0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^(din & DataMask);
`endif
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (bit_end) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        tx_d    = shift_q[0];
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (bit_end) begin
                        s_cnt_d = '0;
                        shift_d = shift_q >> 1;
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            tx_d = parity_q;
`else
                            tx_d = 1'b1;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                            tx_d    = shift_q[1];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (s_tick) begin
                    if (bit_end) begin
                        s_cnt_d = '0;
                        tx_d    = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (stop_end) begin
                        s_cnt_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != StIdle);

endmodule
